// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display scan logic.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    // Active-low anode pattern with only digit idx driven low.
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Wrapping digit-slot counter: counts 0..CLK_DIV-1, flags the last cycle.
// Latency: clr takes effect on the next edge; last is combinational from cnt.
// Backpressure: none; it free-runs unless held in clear.
// Ports: clk, rst (async, active-high), clr (sync clear to 0),
//        cnt (slot position), last (cnt == CLK_DIV-1).
module slot_timer #(
    parameter int CLK_DIV = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    output logic [$clog2(CLK_DIV)-1:0] cnt,
    output logic                       last
);

    localparam int CW = $clog2(CLK_DIV);

    assign last = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with per-slot blanking and frame tick.
// Latency: all outputs registered; en / digit_mask changes show one cycle later.
// Backpressure: none; en=0 darkens the display and restarts the scan on re-enable.
// Ports: clk, rst (async, active-high), en, digit_mask[3:0] (1 = digit enabled),
//        sel[1:0] (mux select), an[3:0] (active-low anodes), blank, frame_tick.
module seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [1:0]            sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  blank,
    output logic                  frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    // Only meaningful when BLANK_CYCLES > 0; BLANK is never entered otherwise.
    localparam int BLANK_END = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [1:0]            sel_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic                  blank_nxt;
    logic                  tick_nxt;
    logic                  lit_nxt;
    logic                  cnt_to_last;
    logic                  clr;
    logic [CW-1:0]         cnt;
    logic                  last;

    // Counter is held at 0 while idle or disabled so each restart begins a fresh slot.
    assign clr = !en || (state == IDLE);

    slot_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_slot_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .cnt  (cnt),
        .last (last)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        if (!en) begin
            state_nxt = IDLE;
            sel_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    sel_nxt   = 2'd0;
                    state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_END)) begin
                        state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (last) begin
                        sel_nxt   = sel + 2'd1;
                        state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    sel_nxt   = 2'd0;
                end
            endcase
        end

        // Outputs are decoded from the next-cycle state so the registered
        // versions line up with the state/sel/cnt they describe.
        lit_nxt     = (state_nxt == SHOW) && digit_mask[sel_nxt];
        an_nxt      = lit_nxt ? an_select(sel_nxt) : AN_OFF;
        blank_nxt   = !lit_nxt;
        // Next cnt equals CLK_DIV-1 exactly when it counts up from CLK_DIV-2.
        cnt_to_last = !clr && (cnt == CW'(CLK_DIV - 2));
        tick_nxt    = (state_nxt != IDLE) && (sel_nxt == 2'd3) && cnt_to_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'd0;
            an         <= AN_OFF;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            an         <= an_nxt;
            blank      <= blank_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. It drives the 2-bit digit select into the 4:1 4-bit digit multiplexer and the matching active-low anode enables, so that one digit at a time is muxed, decoded and lit. It inserts a blanking interval at the start of every digit slot to suppress ghosting, and emits a frame tick once per full scan.

## Interface
- CLK_DIV, default 100000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, default 1000: cycles at the start of each slot with all anodes off; legal range 0 .. CLK_DIV-1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 = display dark and scan held.
- digit_mask  input  4  bit i = 1 enables digit i; a masked digit keeps its time slot but its anode stays off.
- sel  output  2  digit index to the mux select (sel2).
- an  output  4  anode enables, active-low, one-hot-low when lit.
- blank  output  1  high whenever all anodes are forced off.
- frame_tick  output  1  one-cycle pulse on the last cycle of digit 3's slot.

## Operation
- All outputs are registered. Reset values: sel=0, an=4'b1111, blank=1, frame_tick=0, state=IDLE, cnt=0.
- cnt is an unsigned slot counter of width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps to 0.
- States:
  - IDLE: an=1111, blank=1, sel=0, cnt=0. If en=1, go to BLANK next cycle.
  - BLANK: an=1111, blank=1. Stay while cnt < BLANK_CYCLES-1, then go to SHOW. If BLANK_CYCLES=0, BLANK is skipped and each slot starts directly in SHOW.
  - SHOW: an[sel]=~digit_mask[sel], other bits 1; blank=~digit_mask[sel]. At cnt=CLK_DIV-1: sel←sel+1 (3 wraps to 0), cnt←0, next state is BLANK.
- frame_tick=1 for exactly the cycle in which sel=3 and cnt=CLK_DIV-1. It is registered, so it is visible in the same cycle that an for that last cycle is visible.
- When en=0 in any state, the next cycle is IDLE, with the IDLE output values. The partial frame is discarded and no frame_tick is produced.
- When en rises again, scanning restarts at sel=0 from the start of a slot.
- digit_mask is sampled every cycle. A change is reflected on an/blank one cycle later, including mid-slot. sel and timing are never affected by the mask.
- Asynchronous rst mid-slot forces the reset values immediately. Scanning resumes from IDLE after release.
- Invariant: at most one an bit is low. an is never low while in BLANK or IDLE.

## Timing
- Slot length is exactly CLK_DIV cycles. Frame length is 4×CLK_DIV cycles. Refresh rate is f_clk/(4×CLK_DIV).
- After en is sampled high in IDLE:
  - cycle +1: BLANK, sel=0, cnt=0.
  - first lit cycle: +1+BLANK_CYCLES.
- sel changes only at slot boundaries. It is stable for the whole slot, including the blank window, so the mux and decoder settle before the anode turns on.
- Output latency from an en or digit_mask change: 1 cycle.

## Structure
- Package disp_pkg holds:
  - NUM_DIGITS=4
  - AN_OFF=4'b1111
  - typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t
- One sub-module, slot_timer, with parameter CLK_DIV, inputs clk/rst/clr and outputs cnt/last. It provides the wrapping counter and the last-cycle flag. The FSM, sel register and anode decode live in seg_scan_ctrl.

## Test plan
All scenarios use CLK_DIV=8 and BLANK_CYCLES=2.
- Reset/idle: assert rst with en=1 → sel=0, an=1111, blank=1, frame_tick=0 for every cycle while rst=1 and immediately on assertion.
- Basic scan: release rst with en=1 and digit_mask=1111 → an sequence per slot is 1111,1111 then 1110 ×6, then 1111,1111 and 1101 ×6, then 1011, then 0111. sel steps 0→1→2→3→0 every 8 cycles. frame_tick pulses once every 32 cycles, on the last 0111 cycle.
- Masking: digit_mask=1010 → digits 0 and 2 keep an=1111 and blank=1 for their whole slot, and slot timing is unchanged. Toggle bit 1 mid-slot → an[1] follows one cycle later.
- Enable drop: deassert en during sel=2, cnt=4 → the next cycle shows an=1111, sel=0, and there is no frame_tick. Reassert en → the scan restarts with a sel=0 blank window.
- Mid-slot async reset: pulse rst during SHOW of digit 3 → an=1111 and sel=0 with no clock edge. Scanning restarts at digit 0 after release.
- Zero blank: BLANK_CYCLES=0 → each digit is lit for all 8 cycles, and an goes directly from 1110 to 1101 at the slot boundary.
